// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard scoreboard.
// Slots carry a fixed-width destination field so the struct stays unparameterised.
package hazard_pkg;

  localparam int RD_MAX_W = 8;
  localparam int FWD_RF   = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                reg_wr;
    logic                is_load;
  } sb_slot_t;

  function automatic int fwd_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/sb_match.sv
// Youngest-match / readiness search over the in-flight slots for one source operand.
// A match that is not yet ready reports pending instead of a forward select.
module sb_match
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int REG_AW     = 5,
  parameter int FWD_W      = 2
) (
  input  sb_slot_t [NUM_STAGES-1:0] slots,
  input  logic [REG_AW-1:0]         src,
  input  logic                      used,
  output logic [FWD_W-1:0]          fwd,
  output logic                      pending
);

  logic [FWD_W-1:0] fwd_s;
  logic             pending_s;

  // Walk oldest to youngest so the youngest matching slot overwrites the result.
  always_comb begin
    fwd_s     = FWD_W'(FWD_RF);
    pending_s = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (slots[i].valid && slots[i].reg_wr && used &&
          (src != {REG_AW{1'b0}}) && (slots[i].rd == RD_MAX_W'(src))) begin
        if (!slots[i].is_load || (i >= LOAD_LAT)) begin
          fwd_s     = FWD_W'(i + 1);
          pending_s = 1'b0;
        end else begin
          fwd_s     = FWD_W'(FWD_RF);
          pending_s = 1'b1;
        end
      end else begin
        fwd_s     = fwd_s;
        pending_s = pending_s;
      end
    end
  end

  assign fwd     = fwd_s;
  assign pending = pending_s;

endmodule

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight destinations driving forwarding selects,
// load-use stalls, redirect flushes and saturating event counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32,
  localparam int FWD_W     = fwd_width(NUM_STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wr,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  sb_slot_t [NUM_STAGES-1:0] slots_r;
  sb_slot_t                  new_slot_s;
  logic [FWD_W-1:0]          fwd_a_s, fwd_b_s;
  logic                      pend_a_s, pend_b_s;
  logic                      lu_hazard_s, stall_s, issue_s;
  logic [CNT_W-1:0]          stall_cnt_r, flush_cnt_r;

  sb_match #(.NUM_STAGES(NUM_STAGES), .LOAD_LAT(LOAD_LAT), .REG_AW(REG_AW), .FWD_W(FWD_W))
    u_match_a (.slots(slots_r), .src(id_rs1), .used(id_rs1_used), .fwd(fwd_a_s), .pending(pend_a_s));

  sb_match #(.NUM_STAGES(NUM_STAGES), .LOAD_LAT(LOAD_LAT), .REG_AW(REG_AW), .FWD_W(FWD_W))
    u_match_b (.slots(slots_r), .src(id_rs2), .used(id_rs2_used), .fwd(fwd_b_s), .pending(pend_b_s));

  // Redirect outranks a load-use hazard; either one turns the decode slot into a bubble.
  always_comb begin
    lu_hazard_s = id_valid & (pend_a_s | pend_b_s);
    stall_s     = lu_hazard_s & ~ex_redirect;
    issue_s     = id_valid & ~ex_redirect & ~lu_hazard_s;
    new_slot_s  = '0;
    if (issue_s) begin
      new_slot_s.valid   = 1'b1;
      new_slot_s.rd      = RD_MAX_W'(id_rd);
      new_slot_s.reg_wr  = id_reg_wr;
      new_slot_s.is_load = id_is_load;
    end else begin
      new_slot_s = '0;
    end
  end

  assign stall_f   = stall_s;
  assign stall_d   = stall_s;
  assign flush_d   = ex_redirect;
  assign fwd_a     = lu_hazard_s ? FWD_W'(FWD_RF) : fwd_a_s;
  assign fwd_b     = lu_hazard_s ? FWD_W'(FWD_RF) : fwd_b_s;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

  // Slot shift register: older entries always drain regardless of stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots_r <= '0;
    end else begin
      slots_r[0] <= new_slot_s;
      for (int i = 1; i < NUM_STAGES; i++) begin
        slots_r[i] <= slots_r[i-1];
      end
    end
  end

  // Event counters saturate at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (ex_redirect && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a narrow counter so saturation is reachable.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_wr, id_is_load, ex_redirect;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall_f, stall_d, flush_d;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  hazard_scoreboard #(.NUM_STAGES(2), .LOAD_LAT(1), .REG_AW(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a decode instruction at the falling edge, then settle before checks.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic redir);
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_reg_wr = wr; id_is_load = ld; ex_redirect = redir;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_rd = 5'd0; id_reg_wr = 1'b0; id_is_load = 1'b0; ex_redirect = 1'b0;
    #3;
    chk("rst_stall_f", 32'(stall_f), 32'd0);
    chk("rst_flush_d", 32'(flush_d), 32'd0);
    chk("rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ALU chain: addi x5,x1 then add x6,x5,x5
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("addi_fwd_a", 32'(fwd_a), 32'd0);
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("alu_fwd_a", 32'(fwd_a), 32'd1);
    chk("alu_fwd_b", 32'(fwd_b), 32'd1);
    chk("alu_stall", 32'(stall_f), 32'd0);

    // Load-use: lw x7,0(x2) then add x8,x7,x0
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    chk("lw_stall", 32'(stall_f), 32'd0);
    chk("alu_stall_cnt", 32'(stall_cnt), 32'd0);
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    chk("lu_stall_f", 32'(stall_f), 32'd1);
    chk("lu_stall_d", 32'(stall_d), 32'd1);
    chk("lu_fwd_a", 32'(fwd_a), 32'd0);
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    chk("lu_after_stall", 32'(stall_f), 32'd0);
    chk("lu_after_fwd_a", 32'(fwd_a), 32'd2);
    chk("lu_after_fwd_b_x0", 32'(fwd_b), 32'd0);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Writeback-slot forward of x9, then a write to x0 must not forward
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("idle_stall", 32'(stall_f), 32'd0);
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("wb_fwd_a", 32'(fwd_a), 32'd2);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    chk("x0_fwd_a", 32'(fwd_a), 32'd0);
    chk("x0_fwd_b", 32'(fwd_b), 32'd0);

    // Youngest wins: x10 in slot 0 and slot 1
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    chk("x10_single_fwd", 32'(fwd_a), 32'd1);
    drive(1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
    chk("young_fwd_a", 32'(fwd_a), 32'd1);
    chk("young_fwd_b", 32'(fwd_b), 32'd1);

    // Redirect over load-use hazard
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b1);
    chk("redir_flush_d", 32'(flush_d), 32'd1);
    chk("redir_stall_f", 32'(stall_f), 32'd0);
    chk("redir_stall_d", 32'(stall_d), 32'd0);
    drive(1'b1, 5'd14, 1'b1, 5'd15, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0);
    chk("redir_load_fwd", 32'(fwd_a), 32'd2);
    chk("redir_bubble_fwd_b", 32'(fwd_b), 32'd0);
    chk("redir_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("redir_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("redir_flush_clear", 32'(flush_d), 32'd0);

    // Twenty more load-use stalls saturate the 4-bit counter
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      chk("sat_loop_stall", 32'(stall_f), 32'd1);
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);

    // Mid-stream asynchronous reset
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    chk("prereset_stall", 32'(stall_f), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_stall_f", 32'(stall_f), 32'd0);
    chk("async_rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("async_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("async_rst_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("post_rst_stall", 32'(stall_f), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
